// File: rtl/flat_unpacker_pkg.sv
// Helpers for the flatten convention shared by the flat packer/unpacker family.
// Element i of a flattened word occupies bits [(i+1)*width-1 -: width].
package flat_unpacker_pkg;

    localparam int unsigned MaxElemWidth = 256;
    localparam int unsigned MaxFlatWidth = 4096;

    // Index width for a counter over n elements; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

    function automatic logic [MaxElemWidth-1:0] flat_get(
        input logic [MaxFlatWidth-1:0] flat,
        input int unsigned             width,
        input int unsigned             i
    );
        logic [MaxFlatWidth-1:0] shifted;
        logic [MaxElemWidth-1:0] mask;
        shifted = flat >> (i * width);
        mask    = (width >= MaxElemWidth) ? '1 : ~({MaxElemWidth{1'b1}} << width);
        return shifted[MaxElemWidth-1:0] & mask;
    endfunction

endpackage

// File: rtl/flat_unpacker_if.sv
// Word-in / element-out handshake bundle for flat_unpacker.
interface flat_unpacker_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned N_ELEMENTS = 4
);
    import flat_unpacker_pkg::*;

    localparam int unsigned IdxWidth = idx_width(N_ELEMENTS);

    logic [WIDTH*N_ELEMENTS-1:0] i_data;
    logic                        i_valid;
    logic                        i_ready;
    logic [WIDTH-1:0]            o_data;
    logic [IdxWidth-1:0]         o_index;
    logic                        o_last;
    logic                        o_valid;
    logic                        o_ready;

    modport master (
        output i_data, i_valid, o_ready,
        input  i_ready, o_data, o_index, o_last, o_valid
    );

    modport slave (
        input  i_data, i_valid, o_ready,
        output i_ready, o_data, o_index, o_last, o_valid
    );

endinterface

// File: rtl/flat_unpacker.sv
// Serialises one flattened word into N_ELEMENTS single elements, element 0 first.
// Zero-bubble between words via the combinational o_ready -> i_ready path on the last element.
module flat_unpacker
    import flat_unpacker_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned N_ELEMENTS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    flat_unpacker_if.slave  bus
);

    localparam int unsigned       IdxWidth = idx_width(N_ELEMENTS);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(N_ELEMENTS - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                      state_q, state_d;
    logic [IdxWidth-1:0]         idx_q, idx_d;
    logic [WIDTH*N_ELEMENTS-1:0] hold_q, hold_d;

    logic at_last;
    logic in_xfer;
    logic out_xfer;

    assign at_last  = (idx_q == LastIdx);
    assign in_xfer  = bus.i_valid && bus.i_ready;
    assign out_xfer = bus.o_valid && bus.o_ready;

    // Refill is allowed while the last element leaves; held low during reset.
    assign bus.i_ready = reset_n && ((state_q == StIdle) || (bus.o_ready && at_last));

    assign bus.o_valid = (state_q == StSend);
    assign bus.o_index = idx_q;
    assign bus.o_last  = at_last;
    assign bus.o_data  = WIDTH'(flat_get(MaxFlatWidth'(hold_q), WIDTH, 32'(idx_q)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (in_xfer) begin
                    state_d = StSend;
                    hold_d  = bus.i_data;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (out_xfer) begin
                    if (!at_last) begin
                        idx_d = idx_q + IdxWidth'(1);
                    end else if (in_xfer) begin
                        hold_d = bus.i_data;
                        idx_d  = '0;
                    end else begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_flat_unpacker.sv
// Scoreboard bench for flat_unpacker at three geometries: 8x4, 5x3 and 16x1.
module tb_flat_unpacker;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    bit          held [3];
    logic [15:0] hd   [3];
    logic [1:0]  hi   [3];
    logic        hl   [3];
    logic [1:0]  acc_idx;
    logic        acc_valid;

    always #5 clk = ~clk;

    flat_unpacker_if #(.WIDTH(8),  .N_ELEMENTS(4)) if4 ();
    flat_unpacker_if #(.WIDTH(5),  .N_ELEMENTS(3)) if3 ();
    flat_unpacker_if #(.WIDTH(16), .N_ELEMENTS(1)) if1 ();

    flat_unpacker #(.WIDTH(8),  .N_ELEMENTS(4)) u4 (.clk(clk), .reset_n(rst_n), .bus(if4.slave));
    flat_unpacker #(.WIDTH(5),  .N_ELEMENTS(3)) u3 (.clk(clk), .reset_n(rst_n), .bus(if3.slave));
    flat_unpacker #(.WIDTH(16), .N_ELEMENTS(1)) u1 (.clk(clk), .reset_n(rst_n), .bus(if1.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int nel(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 3 : 1;
    endfunction

    function automatic int wid(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 5 : 16;
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
    endfunction

    function automatic logic vld(input int sel);
        return (sel == 0) ? if4.o_valid : (sel == 1) ? if3.o_valid : if1.o_valid;
    endfunction

    // Expected elements of word w: element e is bits [(e+1)*W-1 -: W].
    task automatic push_word(input int sel, input logic [31:0] w);
        exp_t        ex;
        logic [31:0] mask;
        mask = (32'h1 << wid(sel)) - 32'h1;
        for (int e = 0; e < nel(sel); e++) begin
            ex.data = 16'((w >> (e * wid(sel))) & mask);
            ex.idx  = 2'(e);
            ex.last = (e == nel(sel) - 1);
            case (sel)
                0:       q0.push_back(ex);
                1:       q1.push_back(ex);
                default: q2.push_back(ex);
            endcase
        end
    endtask

    task automatic mon(input int sel, input logic v, input logic r, input logic [15:0] d,
                       input logic [1:0] ix, input logic l, input logic ir);
        exp_t e;
        if (!rst_n) begin
            held[sel] = 1'b0;
            return;
        end
        if (v) begin
            check("i_ready_in_send", 32'(ir), 32'(r && l));
            if (held[sel]) begin
                check("stall_data_stable", 32'(d), 32'(hd[sel]));
                check("stall_index_stable", 32'(ix), 32'(hi[sel]));
                check("stall_last_stable", 32'(l), 32'(hl[sel]));
            end
            if (r) begin
                held[sel] = 1'b0;
                if (qsize(sel) == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: dut%0d data %0h idx %0d", sel, d, ix);
                end else begin
                    case (sel)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    check("out_data", 32'(d), 32'(e.data));
                    check("out_index", 32'(ix), 32'(e.idx));
                    check("out_last", 32'(l), 32'(e.last));
                end
            end else begin
                held[sel] = 1'b1;
                hd[sel]   = d;
                hi[sel]   = ix;
                hl[sel]   = l;
            end
        end else begin
            if (held[sel]) check("valid_held_until_xfer", 32'(v), 32'd1);
            held[sel] = 1'b0;
            check("i_ready_idle", 32'(ir), 32'd1);
        end
    endtask

    always @(negedge clk) mon(0, if4.o_valid, if4.o_ready, {8'h0, if4.o_data}, if4.o_index,
                              if4.o_last, if4.i_ready);
    always @(negedge clk) mon(1, if3.o_valid, if3.o_ready, {11'h0, if3.o_data}, if3.o_index,
                              if3.o_last, if3.i_ready);
    always @(negedge clk) mon(2, if1.o_valid, if1.o_ready, if1.o_data, {1'b0, if1.o_index},
                              if1.o_last, if1.i_ready);

    // Presents w and holds i_valid until accepted; leaves i_valid high for back-to-back use.
    task automatic send(input int sel, input logic [31:0] w);
        logic ir;
        bit   done;
        done = 1'b0;
        case (sel)
            0:       begin if4.i_data = w;        if4.i_valid = 1'b1; end
            1:       begin if3.i_data = w[14:0];  if3.i_valid = 1'b1; end
            default: begin if1.i_data = w[15:0];  if1.i_valid = 1'b1; end
        endcase
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            case (sel)
                0:       begin ir = if4.i_ready; acc_idx = if4.o_index; acc_valid = if4.o_valid; end
                1:       begin ir = if3.i_ready; acc_idx = if3.o_index; acc_valid = if3.o_valid; end
                default: begin
                    ir = if1.i_ready; acc_idx = {1'b0, if1.o_index}; acc_valid = if1.o_valid;
                end
            endcase
            @(posedge clk);
            #1;
            if (ir) begin
                done = 1'b1;
                push_word(sel, w);
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: dut%0d word %0h never accepted", sel, w);
        end
    endtask

    task automatic drain(input int sel);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (qsize(sel) == 0 && !vld(sel)) ok = 1'b1;
        end
        check("drain_empty", 32'(qsize(sel)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] pat;
        rst_n = 1'b0;
        if4.i_valid = 1'b0; if4.i_data = '0; if4.o_ready = 1'b1;
        if3.i_valid = 1'b0; if3.i_data = '0; if3.o_ready = 1'b1;
        if1.i_valid = 1'b0; if1.i_data = '0; if1.o_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("i_ready_in_reset_4", 32'(if4.i_ready), 32'd0);
        check("i_ready_in_reset_3", 32'(if3.i_ready), 32'd0);
        check("i_ready_in_reset_1", 32'(if1.i_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_o_valid", 32'(if4.o_valid), 32'd0);
        check("rst_o_data", 32'(if4.o_data), 32'd0);
        check("rst_o_index", 32'(if4.o_index), 32'd0);
        check("rst_o_last_n4", 32'(if4.o_last), 32'd0);
        check("rst_o_last_n1", 32'(if1.o_last), 32'd1);
        check("rst_i_ready", 32'(if4.i_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic word, then latency of element 0.
        send(0, 32'hDDCCBBAA);
        if4.i_valid = 1'b0;
        @(negedge clk);
        check("latency_valid", 32'(if4.o_valid), 32'd1);
        check("latency_index", 32'(if4.o_index), 32'd0);
        drain(0);

        // Back-to-back: second word taken alongside element 3, no gap afterwards.
        send(0, 32'h03020100);
        send(0, 32'h07060504);
        if4.i_valid = 1'b0;
        check("b2b_accept_valid", 32'(acc_valid), 32'd1);
        check("b2b_accept_index", 32'(acc_idx), 32'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b2b_no_gap", 32'(if4.o_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        drain(0);

        // Backpressure with a fixed irregular o_ready pattern; i_data scrambled after.
        pat = 40'hB36C9AD147;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    if4.o_ready = pat[k];
                    @(posedge clk);
                    #1;
                end
                if4.o_ready = 1'b1;
            end
            begin
                send(0, 32'h13121110);
                send(0, 32'h17161514);
                send(0, 32'h1B1A1918);
                if4.i_valid = 1'b0;
                if4.i_data  = 32'h5A5A5A5A;
            end
        join
        drain(0);

        // N=3, W=5: index wraps 2 -> 0 across words.
        send(1, {17'h0, 5'd7, 5'd19, 5'd31});
        send(1, {17'h0, 5'd1, 5'd2, 5'd3});
        if3.i_valid = 1'b0;
        drain(1);

        // N=1, W=16: one word per cycle.
        if1.i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if1.i_data = 16'h1111 * 16'(k + 1);
            push_word(2, {16'h0, if1.i_data});
            @(negedge clk);
            check("n1_i_ready_each_cycle", 32'(if1.i_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        if1.i_valid = 1'b0;
        drain(2);

        // Reset after element 1 discards the rest of the word.
        send(0, 32'h44332211);
        if4.i_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        if4.o_ready = 1'b0;
        @(negedge clk);
        check("midword_reset_i_ready", 32'(if4.i_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if4.o_ready = 1'b1;
        q0.delete();
        @(negedge clk);
        check("post_reset_o_valid", 32'(if4.o_valid), 32'd0);
        check("post_reset_i_ready", 32'(if4.i_ready), 32'd1);
        check("post_reset_o_index", 32'(if4.o_index), 32'd0);
        @(posedge clk);
        #1;
        send(0, 32'h88776655);
        if4.i_valid = 1'b0;
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
